// File: rtl/request_key_encoder.sv
// request_key_encoder
// Turns 5-bit elevator request codes {elev,floor[2:0],down} into PS/2-style key
// events for the keyboard-input FSM. Each request becomes a make pulse, then
// HOLD_CYCLES idle cycles, then a break pulse, then GAP_CYCLES idle cycles.
// Requests are mapped to scan codes on entry and queued in a small FIFO.
// Codes that are not in the map are dropped and reported with an err_code pulse.
module request_key_encoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [4:0]                    req_code,
    output logic                          req_ready,
    output logic                          key_valid,
    output logic [8:0]                    last_change,
    output logic                          busy,
    output logic                          err_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_HOLD    = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Request code to {valid, scan code}; anything outside the map is invalid.
    function automatic logic [9:0] map_code(input logic [4:0] code);
        logic [9:0] res;
        case (code)
            5'b0_001_0: res = {1'b1, 9'h016};
            5'b0_010_0: res = {1'b1, 9'h015};
            5'b0_010_1: res = {1'b1, 9'h01D};
            5'b0_011_0: res = {1'b1, 9'h01C};
            5'b0_011_1: res = {1'b1, 9'h01B};
            5'b0_100_1: res = {1'b1, 9'h022};
            5'b1_001_0: res = {1'b1, 9'h069};
            5'b1_010_0: res = {1'b1, 9'h072};
            5'b1_011_0: res = {1'b1, 9'h07A};
            5'b1_100_0: res = {1'b1, 9'h06B};
            default:    res = {1'b0, 9'h000};
        endcase
        return res;
    endfunction

    // FIFO storage holds already-mapped scan codes
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [8:0]       scan_q;
    logic [8:0]       scan_d;
    logic             key_valid_q;
    logic             key_valid_d;
    logic [8:0]       last_change_q;
    logic [8:0]       last_change_d;
    logic             err_q;
    logic             err_d;

    logic [9:0]       in_map_s;
    logic             full_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    assign in_map_s = map_code(req_code);
    assign full_s   = (count_q == FIFO_FULL);
    assign accept_s = req_valid && !full_s;
    assign push_s   = accept_s && in_map_s[9];
    // The FSM only takes a new entry while idle
    assign pop_s    = (state_q == S_IDLE) && (count_q != '0);
    assign err_d    = accept_s && !in_map_s[9];

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, power-of-two pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= in_map_s[8:0];
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Key-event sequencer: next state, interval counter and registered outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scan_d        = scan_q;
        key_valid_d   = 1'b0;
        last_change_d = last_change_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    scan_d  = mem_q[rd_ptr_q];
                    state_d = S_PRESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS: begin
                key_valid_d   = 1'b1;
                last_change_d = scan_q;
                cnt_d         = '0;
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                // Break reuses the scan code already presented with the make
                key_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers; reset drops any in-flight event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            scan_q        <= 9'h000;
            key_valid_q   <= 1'b0;
            last_change_q <= 9'h000;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scan_q        <= scan_d;
            key_valid_q   <= key_valid_d;
            last_change_q <= last_change_d;
            err_q         <= err_d;
        end
    end

    assign req_ready   = !full_s;
    assign key_valid   = key_valid_q;
    assign last_change = last_change_q;
    assign err_code    = err_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count  = count_q;

endmodule
